// File: rtl/sram_req_adapter_pkg.sv
// Shared types and constants for the core-to-SRAM request adapter.
// FSM states, the pending-response record and word/byte-enable constants.
package sram_adapter_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic is_read;
        logic err;
    } resp_t;

    localparam int unsigned WORD_SHIFT = 2;
    localparam logic [3:0]  BEN_IDLE   = 4'hF;

endpackage

// File: rtl/sram_req_adapter_if.sv
// Core data-port bus: request/grant plus response valid/ready.
// master = core side, slave = adapter side.
interface sram_req_adapter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  req_i;
    logic                  gnt_o;
    logic [31:0]           addr_i;
    logic                  we_i;
    logic [BE_WIDTH-1:0]   be_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  rvalid_o;
    logic                  rready_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, rready_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, rready_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/sram_req_adapter.sv
// Bridges the core req/gnt/rvalid/rready port to an active-low SRAM macro.
// Holds traffic during a post-reset init window, one access outstanding.
module sram_req_adapter
    import sram_adapter_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          DATA_WIDTH  = 32,
    parameter int          BE_WIDTH    = DATA_WIDTH / 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          INIT_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    sram_req_adapter_if.slave     bus,
    output logic                  INITN,
    output logic                  CEN,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  WEN,
    output logic [DATA_WIDTH-1:0] D,
    output logic [BE_WIDTH-1:0]   BEN,
    input  logic [DATA_WIDTH-1:0] Q
);

    localparam logic [7:0]          InitLast = 8'(INIT_CYCLES - 1);
    localparam logic [BE_WIDTH-1:0] BenIdle  = BE_WIDTH'(BEN_IDLE);

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    resp_t                 resp_q, resp_d;
    logic                  first_q;
    logic [DATA_WIDTH-1:0] cap_q;

    logic [31:0] off;
    logic        bad;
    logic        gnt;
    logic        acc;
    logic        rvalid;
    logic        unused_low;

    assign off        = bus.addr_i - BASE_ADDR;
    assign unused_low = ^off[1:0];
    assign bad        = (bus.addr_i[1:0] != 2'b00)
                      | ({2'b00, off[31:WORD_SHIFT]} >= (32'd1 << ADDR_WIDTH));

    // FSM next state, init counter and combinational grant
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == InitLast) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                gnt = bus.req_i;
                if (bus.req_i) state_d = ST_RESP;
            end
            ST_RESP: begin
                gnt = bus.req_i & bus.rready_i;
                if (bus.rready_i & ~bus.req_i) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // a new grant replaces the pending response record
    always_comb begin
        resp_d = resp_q;
        if (gnt) begin
            resp_d.is_read = ~bus.we_i;
            resp_d.err     = bad;
        end
    end

    // state, counter, response record and read-data capture
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_INIT;
            cnt_q   <= 8'd0;
            resp_q  <= '0;
            first_q <= 1'b0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            first_q <= gnt;
            if (first_q) cap_q <= Q;
        end
    end

    assign acc    = gnt & ~bad;
    assign rvalid = (state_q == ST_RESP);

    assign INITN = (state_q != ST_INIT);
    assign CEN   = ~acc;
    assign A     = off[ADDR_WIDTH+WORD_SHIFT-1:WORD_SHIFT];
    assign WEN   = acc ? ~bus.we_i : 1'b1;
    assign D     = bus.wdata_i;
    assign BEN   = (acc & bus.we_i) ? ~bus.be_i : BenIdle;

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid;
    assign bus.err_o    = rvalid & resp_q.err;
    assign bus.rdata_o  = (rvalid & resp_q.is_read & ~resp_q.err)
                        ? (first_q ? Q : cap_q) : '0;

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed bench for sram_req_adapter with a behavioural SRAM model.
// Each task drives one scenario and checks outputs inline.
module tb_sram_req_adapter;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        INITN, CEN, WEN;
    logic [11:0] A;
    logic [31:0] D, Q;
    logic [3:0]  BEN;

    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    sram_req_adapter_if #(.DATA_WIDTH(32)) bus ();

    sram_req_adapter #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .BE_WIDTH(4),
        .BASE_ADDR(32'h0), .INIT_CYCLES(4)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .bus(bus),
        .INITN(INITN), .CEN(CEN), .A(A), .WEN(WEN),
        .D(D), .BEN(BEN), .Q(Q)
    );

    always #5 CLK = ~CLK;

    // SRAM model: Q is only meaningful after a read access
    always @(posedge CLK) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!CEN) begin
            if (!WEN) begin
                for (int b = 0; b < 4; b++)
                    if (!BEN[b]) mem[A][b*8 +: 8] <= D[b*8 +: 8];
                Q <= 32'hDEAD_BEEF;
            end else begin
                Q <= mem[A];
            end
        end else begin
            Q <= 32'hDEAD_BEEF;
        end
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(posedge CLK); #1;
        pl_en = 1'b0;
    endtask

    task automatic test_reset;
        RSTN = 1'b0;
        bus.req_i = 1'b1; bus.addr_i = 32'h0; bus.we_i = 1'b0;
        bus.be_i = 4'hF; bus.wdata_i = 32'h0; bus.rready_i = 1'b1;
        preload(12'd0, 32'hA0A0_A0A0);
        preload(12'd1, 32'hB1B1_B1B1);
        preload(12'd2, 32'hC2C2_C2C2);
        preload(12'd4, 32'h1122_3344);
        preload(12'd8, 32'hCAFE_F00D);
        @(negedge CLK);
        checks++; if (bus.gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", bus.gnt_o); end
        checks++; if (INITN !== 1'b0) begin errors++; $display("FAIL rst_initn got %b exp 0", INITN); end
        checks++; if (CEN !== 1'b1) begin errors++; $display("FAIL rst_cen got %b exp 1", CEN); end
        checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", bus.rvalid_o); end
        checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rdata_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.err_o); end
        @(posedge CLK); #1;
        RSTN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++; if (INITN !== 1'b0) begin errors++; $display("FAIL init_initn[%0d] got %b exp 0", i, INITN); end
            checks++; if (bus.gnt_o !== 1'b0) begin errors++; $display("FAIL init_gnt[%0d] got %b exp 0", i, bus.gnt_o); end
            @(posedge CLK); #1;
        end
        bus.req_i = 1'b0;
        @(negedge CLK);
        checks++; if (INITN !== 1'b1) begin errors++; $display("FAIL init_done got %b exp 1", INITN); end
        @(posedge CLK); #1;
    endtask

    task automatic test_write_read;
        bus.req_i = 1'b1; bus.addr_i = 32'h10; bus.we_i = 1'b1;
        bus.be_i = 4'b0011; bus.wdata_i = 32'hAABB_CCDD; bus.rready_i = 1'b1;
        @(negedge CLK);
        checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", bus.gnt_o); end
        checks++; if (CEN !== 1'b0) begin errors++; $display("FAIL wr_cen got %b exp 0", CEN); end
        checks++; if (A !== 12'd4) begin errors++; $display("FAIL wr_a got %h exp 4", A); end
        checks++; if (WEN !== 1'b0) begin errors++; $display("FAIL wr_wen got %b exp 0", WEN); end
        checks++; if (BEN !== 4'b1100) begin errors++; $display("FAIL wr_ben got %b exp 1100", BEN); end
        checks++; if (D !== 32'hAABB_CCDD) begin errors++; $display("FAIL wr_d got %h exp aabbccdd", D); end
        @(posedge CLK); #1;
        bus.we_i = 1'b0; bus.be_i = 4'hF;
        @(negedge CLK);
        checks++; if (bus.rvalid_o !== 1'b1) begin errors++; $display("FAIL wr_rvalid got %b exp 1", bus.rvalid_o); end
        checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h exp 0", bus.rdata_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", bus.err_o); end
        checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b exp 1", bus.gnt_o); end
        checks++; if ({CEN, WEN, BEN} !== 6'b01_1111) begin errors++; $display("FAIL rd_pins got %b exp 011111", {CEN, WEN, BEN}); end
        @(posedge CLK); #1;
        bus.we_i = 1'b1; bus.be_i = 4'b0000; bus.wdata_i = 32'h5555_5555;
        @(negedge CLK);
        checks++; if (bus.rvalid_o !== 1'b1) begin errors++; $display("FAIL rd_rvalid got %b exp 1", bus.rvalid_o); end
        checks++; if (bus.rdata_o !== 32'h1122_CCDD) begin errors++; $display("FAIL rd_rdata got %h exp 1122ccdd", bus.rdata_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", bus.err_o); end
        checks++; if ({CEN, WEN, BEN} !== 6'b00_1111) begin errors++; $display("FAIL be0_pins got %b exp 001111", {CEN, WEN, BEN}); end
        @(posedge CLK); #1;
        bus.req_i = 1'b0;
        @(negedge CLK);
        checks++; if ({bus.rvalid_o, bus.err_o} !== 2'b10) begin errors++; $display("FAIL be0_resp got %b exp 10", {bus.rvalid_o, bus.err_o}); end
        checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL be0_rdata got %h exp 0", bus.rdata_o); end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL wr_idle got %b exp 0", bus.rvalid_o); end
        @(posedge CLK); #1;
    endtask

    task automatic test_stall;
        bus.req_i = 1'b1; bus.addr_i = 32'h20; bus.we_i = 1'b0;
        bus.be_i = 4'hF; bus.rready_i = 1'b0;
        @(negedge CLK);
        checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL st_gnt got %b exp 1", bus.gnt_o); end
        @(posedge CLK); #1;
        bus.addr_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++; if (bus.rvalid_o !== 1'b1) begin errors++; $display("FAIL st_rvalid[%0d] got %b exp 1", i, bus.rvalid_o); end
            checks++; if (bus.rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL st_rdata[%0d] got %h exp cafef00d", i, bus.rdata_o); end
            checks++; if ({bus.gnt_o, CEN} !== 2'b01) begin errors++; $display("FAIL st_hold[%0d] got %b exp 01", i, {bus.gnt_o, CEN}); end
            @(posedge CLK); #1;
        end
        bus.rready_i = 1'b1;
        @(negedge CLK);
        checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL st_regnt got %b exp 1", bus.gnt_o); end
        checks++; if (bus.rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL st_last got %h exp cafef00d", bus.rdata_o); end
        @(posedge CLK); #1;
        bus.req_i = 1'b0;
        @(negedge CLK);
        checks++; if (bus.rdata_o !== 32'hA0A0_A0A0) begin errors++; $display("FAIL st_next got %h exp a0a0a0a0", bus.rdata_o); end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] ad [3];
        logic [31:0] ex [3];
        ad[0] = 32'h0; ad[1] = 32'h4; ad[2] = 32'h8;
        ex[0] = 32'hA0A0_A0A0; ex[1] = 32'hB1B1_B1B1; ex[2] = 32'hC2C2_C2C2;
        bus.we_i = 1'b0; bus.rready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin bus.req_i = 1'b1; bus.addr_i = ad[i]; end
            else bus.req_i = 1'b0;
            @(negedge CLK);
            if (i < 3) begin
                checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got %b exp 1", i, bus.gnt_o); end
            end
            if (i > 0) begin
                checks++; if (bus.rvalid_o !== 1'b1) begin errors++; $display("FAIL b2b_rvalid[%0d] got %b exp 1", i, bus.rvalid_o); end
                checks++; if (bus.rdata_o !== ex[i-1]) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, bus.rdata_o, ex[i-1]); end
            end
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", bus.rvalid_o); end
        @(posedge CLK); #1;
    endtask

    task automatic test_errors;
        bus.req_i = 1'b1; bus.addr_i = 32'h4002; bus.we_i = 1'b0; bus.rready_i = 1'b1;
        @(negedge CLK);
        checks++; if ({bus.gnt_o, CEN} !== 2'b11) begin errors++; $display("FAIL mis_acc got %b exp 11", {bus.gnt_o, CEN}); end
        @(posedge CLK); #1;
        bus.addr_i = 32'h4000;
        @(negedge CLK);
        checks++; if ({bus.rvalid_o, bus.err_o} !== 2'b11) begin errors++; $display("FAIL mis_resp got %b exp 11", {bus.rvalid_o, bus.err_o}); end
        checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL mis_rdata got %h exp 0", bus.rdata_o); end
        checks++; if ({bus.gnt_o, CEN} !== 2'b11) begin errors++; $display("FAIL oor_acc got %b exp 11", {bus.gnt_o, CEN}); end
        @(posedge CLK); #1;
        bus.req_i = 1'b0;
        @(negedge CLK);
        checks++; if ({bus.rvalid_o, bus.err_o} !== 2'b11) begin errors++; $display("FAIL oor_resp got %b exp 11", {bus.rvalid_o, bus.err_o}); end
        checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h exp 0", bus.rdata_o); end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++; if ({bus.rvalid_o, bus.err_o} !== 2'b00) begin errors++; $display("FAIL err_idle got %b exp 00", {bus.rvalid_o, bus.err_o}); end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_resp;
        bus.req_i = 1'b1; bus.addr_i = 32'h4; bus.we_i = 1'b0; bus.rready_i = 1'b0;
        @(negedge CLK);
        checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL mr_gnt got %b exp 1", bus.gnt_o); end
        @(posedge CLK); #1;
        bus.req_i = 1'b0;
        @(negedge CLK);
        checks++; if (bus.rvalid_o !== 1'b1) begin errors++; $display("FAIL mr_rvalid got %b exp 1", bus.rvalid_o); end
        #1 RSTN = 1'b0;
        #1;
        checks++; if ({bus.rvalid_o, INITN} !== 2'b00) begin errors++; $display("FAIL mr_drop got %b exp 00", {bus.rvalid_o, INITN}); end
        @(posedge CLK); #1;
        RSTN = 1'b1; bus.req_i = 1'b1; bus.rready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++; if ({bus.gnt_o, INITN} !== 2'b00) begin errors++; $display("FAIL mr_init[%0d] got %b exp 00", i, {bus.gnt_o, INITN}); end
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        checks++; if ({bus.gnt_o, INITN} !== 2'b11) begin errors++; $display("FAIL mr_regnt got %b exp 11", {bus.gnt_o, INITN}); end
        @(posedge CLK); #1;
        bus.req_i = 1'b0;
        @(negedge CLK);
        checks++; if (bus.rdata_o !== 32'hB1B1_B1B1) begin errors++; $display("FAIL mr_rdata got %h exp b1b1b1b1", bus.rdata_o); end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_stall();
        test_back_to_back();
        test_errors();
        test_reset_mid_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
